// File: rtl/dmem_lsu.sv
// Load/store unit between the MEM stage and a big-endian, word-wide data memory.
// Handles byte/half/word loads (sign/zero extended) and stores (read-modify-write
// for sub-word), with alignment fault detection.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_write, req_size,         request type, size (00 b, 01 h, 10 w, 11 rsvd),
//   req_unsigned, req_addr,      load extension mode, byte address,
//   req_wdata                    right-justified store data
//   resp_valid                   one-cycle completion pulse
//   resp_rdata, resp_fault       extended load data / fault flag, held until next response
//   mem_read, mem_write,         data-memory strobes
//   mem_addr, mem_wdata          word-aligned address, big-endian write data
//   mem_rdata                    data-memory read data (combinational)
module dmem_lsu #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t              state, state_next;
  logic                accept_c;
  logic                req_fault_c;
  logic                r_write;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   wbuf;
  logic [1:0]          off_c;
  logic [4:0]          bsh_c;
  logic [4:0]          hsh_c;
  logic [DATA_W-1:0]   bword_c;
  logic [DATA_W-1:0]   hword_c;
  logic [DATA_W-1:0]   load_c;
  logic [DATA_W-1:0]   merge_c;
  logic [ADDR_W-1:0]   base_c;

  // Alignment / reserved-size fault decode on the incoming request.
  function automatic logic is_fault(input logic [1:0] size, input logic [1:0] off);
    logic f;
    case (size)
      2'b00:   f = 1'b0;
      2'b01:   f = off[0];
      2'b10:   f = (off != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  assign accept_c    = req_valid && (state == IDLE);
  assign req_fault_c = is_fault(req_size, req_addr[1:0]);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic. Word stores skip the read; sub-word stores read first.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if (req_fault_c)                          state_next = RESP;
          else if (req_write && req_size == 2'b10) state_next = WR;
          else                                      state_next = RD;
        end
      end
      RD:      state_next = r_write ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Big-endian lane shifts: byte at off sits at bit 8*(3-off), half at 8*(2-off).
  assign off_c   = r_addr[1:0];
  assign bsh_c   = {2'(2'd3 - off_c), 3'b000};
  assign hsh_c   = {2'(2'd2 - off_c), 3'b000};
  assign bword_c = mem_rdata >> bsh_c;
  assign hword_c = mem_rdata >> hsh_c;
  assign base_c  = {r_addr[ADDR_W-1:2], 2'b00};

  // Load extraction with extension, and store lane merge into the old word.
  always_comb begin
    load_c  = mem_rdata;
    merge_c = r_wdata_word();
    case (r_size)
      2'b00: begin
        load_c  = r_unsigned ? {24'd0, bword_c[7:0]} : {{24{bword_c[7]}}, bword_c[7:0]};
        merge_c = (mem_rdata & ~(32'h0000_00FF << bsh_c)) | ({24'd0, wbuf[7:0]} << bsh_c);
      end
      2'b01: begin
        load_c  = r_unsigned ? {16'd0, hword_c[15:0]} : {{16{hword_c[15]}}, hword_c[15:0]};
        merge_c = (mem_rdata & ~(32'h0000_FFFF << hsh_c)) | ({16'd0, wbuf[15:0]} << hsh_c);
      end
      default: ;
    endcase
  end

  function automatic logic [DATA_W-1:0] r_wdata_word();
    return wbuf;
  endfunction

  // Request capture, write buffer and response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_write    <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      wbuf       <= '0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      if (accept_c) begin
        r_write    <= req_write;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_addr     <= req_addr;
        wbuf       <= req_wdata;
        if (req_fault_c) begin
          resp_fault <= 1'b1;
          resp_rdata <= '0;
        end
      end
      if (state == RD) begin
        if (r_write) begin
          wbuf <= merge_c;
        end else begin
          resp_rdata <= load_c;
          resp_fault <= 1'b0;
        end
      end
      if (state == WR) begin
        resp_rdata <= '0;
        resp_fault <= 1'b0;
      end
    end
  end

  // Handshake and memory bus decode; a reset during WR suppresses the write.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_read   = (state == RD);
  assign mem_write  = (state == WR) && !reset;
  assign mem_addr   = (state == RD || state == WR) ? base_c : '0;
  assign mem_wdata  = (state == WR) ? wbuf : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  dmem_lsu #(.ADDR_W(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Big-endian byte memory model with combinational read.
  logic [7:0] mem [256];
  assign mem_rdata = mem_read ? {mem[mem_addr], mem[mem_addr + 8'd1],
                                 mem[mem_addr + 8'd2], mem[mem_addr + 8'd3]}
                              : 32'hDEAD_BEEF;
  always @(posedge clock) begin
    if (mem_write) begin
      mem[mem_addr]        <= mem_wdata[31:24];
      mem[mem_addr + 8'd1] <= mem_wdata[23:16];
      mem[mem_addr + 8'd2] <= mem_wdata[15:8];
      mem[mem_addr + 8'd3] <= mem_wdata[7:0];
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        fault;
    int          rcyc;
    int          nrd;
    int          nwr;
    logic [7:0]  addr;
    logic [31:0] wd;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: tallies bus activity per transaction and scores each response.
  int          rd_cnt = 0, wr_cnt = 0;
  logic [7:0]  rd_a, wr_a;
  logic [31:0] wr_d;
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        if (mem_read)  begin rd_cnt++; rd_a = mem_addr; end
        if (mem_write) begin wr_cnt++; wr_a = mem_addr; wr_d = mem_wdata; end
        if (!mem_read && !mem_write)
          check("bus_idle", {mem_addr, mem_wdata[23:0]} | {24'd0, mem_wdata[31:24]}, 32'd0);
        if (resp_valid) begin
          if (q.size() == 0) begin
            check("unexpected_resp", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            check({e.name, "_rdata"}, resp_rdata, e.rdata);
            check({e.name, "_fault"}, {31'd0, resp_fault}, {31'd0, e.fault});
            check({e.name, "_latency"}, 32'(cyc), 32'(e.rcyc));
            check({e.name, "_nread"}, 32'(rd_cnt), 32'(e.nrd));
            check({e.name, "_nwrite"}, 32'(wr_cnt), 32'(e.nwr));
            if (e.nrd > 0) check({e.name, "_rdaddr"}, {24'd0, rd_a}, {24'd0, e.addr});
            if (e.nwr > 0) begin
              check({e.name, "_wraddr"}, {24'd0, wr_a}, {24'd0, e.addr});
              check({e.name, "_wdata"}, wr_d, e.wd);
            end
          end
          rd_cnt = 0;
          wr_cnt = 0;
        end
      end
    end
  end

  // Present a request (req_valid stays high afterwards) and queue its expectation.
  task automatic issue(input string nm, input logic wr, input logic [1:0] sz, input logic un,
                       input logic [7:0] a, input logic [31:0] wd, input logic [31:0] er,
                       input logic ef, input int lat, input int nrd, input int nwr,
                       input logic [31:0] ewd);
    exp_t e;
    int guard = 0;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = un;
    req_addr = a; req_wdata = wd;
    while (!req_ready && guard < 20) begin
      @(posedge clock); #1;
      guard++;
    end
    if (!req_ready) begin
      check({nm, "_accept_timeout"}, 32'd0, 32'd1);
    end else begin
      e.name = nm; e.rdata = er; e.fault = ef; e.rcyc = cyc + lat;
      e.nrd = nrd; e.nwr = nwr; e.addr = {a[7:2], 2'b00}; e.wd = ewd;
      q.push_back(e);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    int guard;
    foreach (mem[i]) mem[i] = 8'h5A;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 8'h00; req_wdata = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
    check("rst_mem_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    //    name     wr sz     un  addr   wdata          exp rdata      flt lat rd wr exp wdata
    issue("sw10",  1, 2'b10, 0, 8'h10, 32'hA1B2C3D4, 32'h0,         0,  2,  0, 1, 32'hA1B2C3D4);
    issue("lw10",  0, 2'b10, 0, 8'h10, 32'h0,        32'hA1B2C3D4,  0,  2,  1, 0, 32'h0);
    issue("lb11",  0, 2'b00, 0, 8'h11, 32'h0,        32'hFFFFFFB2,  0,  2,  1, 0, 32'h0);
    issue("lbu11", 0, 2'b00, 1, 8'h11, 32'h0,        32'h000000B2,  0,  2,  1, 0, 32'h0);
    issue("lb13",  0, 2'b00, 0, 8'h13, 32'h0,        32'hFFFFFFD4,  0,  2,  1, 0, 32'h0);
    issue("lh12",  0, 2'b01, 0, 8'h12, 32'h0,        32'hFFFFC3D4,  0,  2,  1, 0, 32'h0);
    issue("lhu10", 0, 2'b01, 1, 8'h10, 32'h0,        32'h0000A1B2,  0,  2,  1, 0, 32'h0);
    issue("sb13",  1, 2'b00, 0, 8'h13, 32'h000000EE, 32'h0,         0,  3,  1, 1, 32'hA1B2C3EE);
    issue("lw10b", 0, 2'b10, 0, 8'h10, 32'h0,        32'hA1B2C3EE,  0,  2,  1, 0, 32'h0);
    issue("sh10",  1, 2'b01, 0, 8'h10, 32'h00001234, 32'h0,         0,  3,  1, 1, 32'h1234C3EE);
    issue("lw10c", 0, 2'b10, 0, 8'h10, 32'h0,        32'h1234C3EE,  0,  2,  1, 0, 32'h0);
    issue("sb10",  1, 2'b00, 0, 8'h10, 32'hFFFFFF77, 32'h0,         0,  3,  1, 1, 32'h7734C3EE);
    issue("lb10",  0, 2'b00, 0, 8'h10, 32'h0,        32'h00000077,  0,  2,  1, 0, 32'h0);
    issue("sh12",  1, 2'b01, 0, 8'h12, 32'hABCD9876, 32'h0,         0,  3,  1, 1, 32'h77349876);
    issue("lh12b", 0, 2'b01, 0, 8'h12, 32'h0,        32'hFFFF9876,  0,  2,  1, 0, 32'h0);
    issue("f_sh11",1, 2'b01, 0, 8'h11, 32'h0000FFFF, 32'h0,         1,  1,  0, 0, 32'h0);
    issue("f_lw12",0, 2'b10, 0, 8'h12, 32'h0,        32'h0,         1,  1,  0, 0, 32'h0);
    issue("f_sz3", 1, 2'b11, 0, 8'h10, 32'hFFFFFFFF, 32'h0,         1,  1,  0, 0, 32'h0);
    issue("lw10d", 0, 2'b10, 0, 8'h10, 32'h0,        32'h77349876,  0,  2,  1, 0, 32'h0);
    issue("swFC",  1, 2'b10, 0, 8'hFC, 32'h11223344, 32'h0,         0,  2,  0, 1, 32'h11223344);
    issue("lwFC",  0, 2'b10, 0, 8'hFC, 32'h0,        32'h11223344,  0,  2,  1, 0, 32'h0);

    // Sub-word store to the top byte, killed by reset during its WR cycle.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 8'hFF; req_wdata = 32'h00000055;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clock); #1;
      guard++;
    end
    check("sbFF_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    check("sbFF_in_wr", {31'd0, mem_write}, 32'd1);
    reset = 1'b1;
    #1;
    check("sbFF_rst_no_write", {31'd0, mem_write}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);

    issue("lwFCb", 0, 2'b10, 0, 8'hFC, 32'h0,        32'h11223344,  0,  2,  1, 0, 32'h0);
    issue("lbuFF", 0, 2'b00, 1, 8'hFF, 32'h0,        32'h00000044,  0,  2,  1, 0, 32'h0);
    req_valid = 1'b0;

    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      @(posedge clock);
      guard++;
    end
    if (q.size() != 0) check("resp_drain_timeout", 32'(q.size()), 32'd0);
    repeat (4) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
